uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial receiver (8N1, optional even parity) that feeds the byte-level consumer stage.
- Provides the consumer handshake: enable_recv, data_ready, waiting_data, and a byte bus.
- Oversamples rxd, majority-votes each bit at mid-bit, and emits a one-cycle data_ready pulse per good frame.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; must be ≥ 8 and even.
- Derived: DIV = max(1, round(CLK_FREQ / (BAUD * OVERSAMPLE))), the clocks per tick.

Ports:
- clk  input  1  system clock; all flops on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rxd  input  1  serial line; idle high; asynchronous to clk.
- enable_recv  input  1  consumer permits a new frame to start.
- data  output  8  last good byte, LSB received first.
- data_ready  output  1  one-cycle pulse when data has been updated.
- waiting_data  output  1  high while FSM is in IDLE.
- frame_error  output  1  one-cycle pulse on bad stop bit.
- parity_error  output  1  one-cycle pulse on parity mismatch; constant 0 when the feature is disabled.

Behaviour:
- Reset (rst low, async):
  - data=0, data_ready=0, frame_error=0, parity_error=0, waiting_data=1.
  - FSM=IDLE; all counters 0; synchronizer flops=1.
  - Reset asserted mid-frame abandons the frame silently.
- Input path: rxd passes through a 2-flop synchronizer to give rxs. All decisions use rxs.
- Tick generator:
  - Counter 0..DIV-1; tick asserts when it wraps.
  - Counter is cleared on entry to START, so sampling is aligned to the detected edge.
- Oversample counter os counts 0..OVERSAMPLE-1 on ticks.
- Vote: majority of the rxs samples at os = M-1, M, M+1, where M = OVERSAMPLE/2.
- Decision point: the tick at os = M+1.
- States:
  - IDLE: waiting_data=1. If rxs==0 and enable_recv==1: go to START, os=0. A start edge with enable_recv==0 is ignored; the FSM stays IDLE until the line is seen low with enable_recv high.
  - START: at the decision point, vote==0 goes to DATA with bit index 0; vote==1 is a glitch and returns to IDLE with no pulse.
  - DATA: at each decision point, shift vote into shift[7] (right shift). After bit 7, go to PARITY if the feature is enabled, else STOP.
  - PARITY: at the decision point, store the parity bit, then go to STOP.
  - STOP: at the decision point:
    - vote==1 and parity ok: data<=shift and data_ready=1 on the next clock; go to IDLE immediately. This allows resync on a start edge in the second half of the stop bit.
    - vote==0: frame_error pulse; data unchanged; go to BREAK.
    - Parity mismatch with a good stop bit: parity_error pulse; data unchanged; go to IDLE.
  - BREAK: wait for rxs==1, then go to IDLE. waiting_data=0 throughout.
- waiting_data=0 in all states other than IDLE.
- enable_recv only gates frame start. A frame already in progress completes and pulses normally even if enable_recv drops.
- Latency: data_ready rises 2 (synchronizer) + ~(9.5 or 10.5 bits) × OVERSAMPLE × DIV clocks after the rxd falling edge.
- data is held stable between pulses; the consumer samples it during the data_ready cycle or any time after.
- At most one of data_ready, frame_error, parity_error is asserted in any cycle.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: frame is start, 8 data bits, even-parity bit, stop. Parity ok ⇔ XOR(data bits, parity bit)==0. parity_error is driven as described above.
- Undefined: 8N1 only; PARITY state is absent; parity_error is tied 0.

Test Plan:
- Common setup: CLK_FREQ=1600, BAUD=100, OVERSAMPLE=16, giving DIV=1 and 16 clocks/bit; enable_recv=1 unless stated.
- Send 0x55 8N1 → exactly one data_ready pulse, data=0x55, frame_error=0. waiting_data=0 during the frame and returns to 1 after the stop-bit decision.
- Back-to-back 0xA3 then 0x00, with 1 stop bit and no idle gap → two pulses in order, data=0xA3 then 0x00. 0x00 must not raise frame_error.
- rxd low for 4 clocks then high (glitch) → START aborts, no pulse on any output, waiting_data back to 1 within 12 clocks.
- Prime the receiver with 0x11, then send 0xFF with the stop bit low and hold rxd low 40 clocks before raising it → one frame_error pulse, no data_ready, data stays 0x11. waiting_data=0 until rxs is high, then 1.
- Case (a): enable_recv=0, send 0x12 → no pulse, data unchanged. Case (b): assert rst low for 3 clocks during data bit 4 of 0x7E → all outputs hold reset values. After release and one idle bit, 0x3C is received correctly.
- With UART_RX_PARITY_EN: send 0x03 with parity 0 → data_ready, data=0x03. Send 0x03 with parity 1 → parity_error pulse, no data_ready.

Source files
------------

// File: rtl/uart_rx_if.sv
// Consumer-side handshake bundle for the uart_rx receiver.
// The master modport is the receiver, which produces bytes; the slave modport is the consumer.
interface uart_rx_if;
   logic       enable_recv;
   logic [7:0] data;
   logic       data_ready;
   logic       waiting_data;
   logic       frame_error;
   logic       parity_error;

   modport master (
      input  enable_recv,
      output data,
      output data_ready,
      output waiting_data,
      output frame_error,
      output parity_error
   );

   modport slave (
      output enable_recv,
      input  data,
      input  data_ready,
      input  waiting_data,
      input  frame_error,
      input  parity_error
   );
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with mid-bit majority vote and a byte handshake.
// Define UART_RX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_rx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      rxd,
   uart_rx_if.master bus
);

   localparam int TICK_DEN = BAUD * OVERSAMPLE;
   localparam int DIV_RAW  = (CLK_FREQ + TICK_DEN / 2) / TICK_DEN;
   localparam int DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int OS_W     = $clog2(OVERSAMPLE);
   localparam int M        = OVERSAMPLE / 2;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_VOTE0 = OS_W'(M - 1);
   localparam logic [OS_W-1:0]  OS_VOTE1 = OS_W'(M);
   localparam logic [OS_W-1:0]  OS_DECIDE = OS_W'(M + 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK} state_t;
`else
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;
`endif

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q;
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [OS_W-1:0]  os_q, os_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shift_q, shift_d;
   logic             v0_q, v0_d;
   logic             v1_q, v1_d;
   logic [7:0]       data_q, data_d;
   logic             data_ready_q, data_ready_d;
   logic             waiting_data_q, waiting_data_d;
   logic             frame_error_q, frame_error_d;
`ifdef UART_RX_PARITY_EN
   logic             parity_bit_q, parity_bit_d;
   logic             parity_error_q, parity_error_d;
`endif

   logic rxs;
   logic tick;
   logic decide;
   logic vote;
   logic parity_ok;

   assign rxs    = sync2_q;
   assign tick   = (div_cnt_q == DIV_LAST);
   assign decide = tick && (os_q == OS_DECIDE);
   // Third vote sample is the live line value at the decision tick.
   assign vote   = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);

`ifdef UART_RX_PARITY_EN
   assign parity_ok = ~(^{shift_q, parity_bit_q});
`else
   assign parity_ok = 1'b1;
`endif

   always_comb begin
      state_d        = state_q;
      div_cnt_d      = div_cnt_q;
      os_d           = os_q;
      bit_cnt_d      = bit_cnt_q;
      shift_d        = shift_q;
      v0_d           = v0_q;
      v1_d           = v1_q;
      data_d         = data_q;
      data_ready_d   = 1'b0;
      frame_error_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_d   = parity_bit_q;
      parity_error_d = 1'b0;
`endif

      // Tick and oversample counters sit at zero in IDLE so START begins aligned to the edge.
      if (state_q == ST_IDLE) begin
         div_cnt_d = '0;
         os_d      = '0;
      end else begin
         div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
         if (tick) begin
            os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
            if (os_q == OS_VOTE0) begin
               v0_d = rxs;
            end
            if (os_q == OS_VOTE1) begin
               v1_d = rxs;
            end
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (!rxs && bus.enable_recv) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (decide) begin
               if (!vote) begin
                  state_d   = ST_DATA;
                  bit_cnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (decide) begin
               shift_d = {vote, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (decide) begin
               parity_bit_d = vote;
               state_d      = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            // Leaving at mid-stop lets a start edge in the second half of the stop bit resync.
            if (decide) begin
               if (!vote) begin
                  frame_error_d = 1'b1;
                  state_d       = ST_BREAK;
               end else if (parity_ok) begin
                  data_d       = shift_q;
                  data_ready_d = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
`ifdef UART_RX_PARITY_EN
                  parity_error_d = 1'b1;
`endif
                  state_d = ST_IDLE;
               end
            end
         end
         ST_BREAK: begin
            if (rxs) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      waiting_data_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= ST_IDLE;
         sync1_q        <= 1'b1;
         sync2_q        <= 1'b1;
         div_cnt_q      <= '0;
         os_q           <= '0;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         v0_q           <= 1'b1;
         v1_q           <= 1'b1;
         data_q         <= '0;
         data_ready_q   <= 1'b0;
         waiting_data_q <= 1'b1;
         frame_error_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_bit_q   <= 1'b0;
         parity_error_q <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         sync1_q        <= rxd;
         sync2_q        <= sync1_q;
         div_cnt_q      <= div_cnt_d;
         os_q           <= os_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         v0_q           <= v0_d;
         v1_q           <= v1_d;
         data_q         <= data_d;
         data_ready_q   <= data_ready_d;
         waiting_data_q <= waiting_data_d;
         frame_error_q  <= frame_error_d;
`ifdef UART_RX_PARITY_EN
         parity_bit_q   <= parity_bit_d;
         parity_error_q <= parity_error_d;
`endif
      end
   end

   assign bus.data         = data_q;
   assign bus.data_ready   = data_ready_q;
   assign bus.waiting_data = waiting_data_q;
   assign bus.frame_error  = frame_error_q;
`ifdef UART_RX_PARITY_EN
   assign bus.parity_error = parity_error_q;
`else
   assign bus.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios plus random bytes against a byte-level model.
// Build with UART_RX_PARITY_EN defined to also exercise the parity scenario.
module tb_uart_rx;

   localparam int CLK_FREQ   = 1600;
   localparam int BAUD       = 100;
   localparam int OVERSAMPLE = 16;
   localparam int BIT_CLKS   = CLK_FREQ / BAUD;

   logic clk;
   logic rst;
   logic rxd;

   uart_rx_if bus ();

   uart_rx #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .OVERSAMPLE (OVERSAMPLE)
   ) dut (
      .clk (clk),
      .rst (rst),
      .rxd (rxd),
      .bus (bus)
   );

   int n_vec;
   int n_err;

   int         ready_cnt;
   int         ferr_cnt;
   int         perr_cnt;
   int         excl_viol;
   logic       wd_low_seen;
   logic       wd_at_ready;
   logic [7:0] rx_q[$];

   logic [7:0] exp_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte-level observer: every pulse is counted and every delivered byte is queued in order.
   always @(negedge clk) begin
      if (bus.data_ready === 1'b1) begin
         ready_cnt++;
         rx_q.push_back(bus.data);
         wd_at_ready = bus.waiting_data;
      end
      if (bus.frame_error === 1'b1) ferr_cnt++;
      if (bus.parity_error === 1'b1) perr_cnt++;
      if (int'(bus.data_ready) + int'(bus.frame_error) + int'(bus.parity_error) > 1) excl_viol++;
      if (bus.waiting_data === 1'b0) wd_low_seen = 1'b1;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "[TB] watchdog");
   end

   task automatic drive_bit(input logic v);
      rxd = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit((^b) ^ par_flip);
`else
      if (par_flip) rxd = 1'b1;
`endif
      drive_bit(stop_bit);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      rxd = 1'b1;
      bus.enable_recv = 1'b1;
      repeat (4) @(negedge clk);
      n_vec++;
      if (bus.data !== 8'h00 || bus.data_ready !== 1'b0 || bus.frame_error !== 1'b0 ||
          bus.parity_error !== 1'b0 || bus.waiting_data !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL reset_values: got data=%h rdy=%b ferr=%b perr=%b wait=%b expected 00 0 0 0 1",
                  bus.data, bus.data_ready, bus.frame_error, bus.parity_error, bus.waiting_data);
      end
      rst = 1'b1;
      idle(BIT_CLKS);
      n_vec++;
      if (bus.waiting_data !== 1'b1 || ready_cnt !== 0) begin
         n_err++;
         $display("[TB] FAIL post_reset_idle: got wait=%b pulses=%0d expected 1 0", bus.waiting_data, ready_cnt);
      end
      exp_data = 8'h00;
   endtask

   task automatic test_basic();
      int r0, f0;
      r0 = ready_cnt;
      f0 = ferr_cnt;
      rx_q.delete();
      wd_low_seen = 1'b0;
      wd_at_ready = 1'b0;
      send_frame(8'h55, 1'b1, 1'b0);
      idle(4);
      exp_data = 8'h55;
      n_vec++;
      if (ready_cnt - r0 !== 1 || ferr_cnt - f0 !== 0) begin
         n_err++;
         $display("[TB] FAIL basic_pulses: got rdy=%0d ferr=%0d expected 1 0", ready_cnt - r0, ferr_cnt - f0);
      end
      n_vec++;
      if (bus.data !== exp_data || rx_q.size() != 1 || rx_q[0] !== exp_data) begin
         n_err++;
         $display("[TB] FAIL basic_data: got %h expected %h", bus.data, exp_data);
      end
      n_vec++;
      if (wd_low_seen !== 1'b1 || wd_at_ready !== 1'b1 || bus.waiting_data !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL basic_waiting: got low_seen=%b at_ready=%b now=%b expected 1 1 1",
                  wd_low_seen, wd_at_ready, bus.waiting_data);
      end
   endtask

   task automatic test_back_to_back();
      int r0, f0;
      r0 = ready_cnt;
      f0 = ferr_cnt;
      rx_q.delete();
      send_frame(8'hA3, 1'b1, 1'b0);
      send_frame(8'h00, 1'b1, 1'b0);
      idle(4);
      exp_data = 8'h00;
      n_vec++;
      if (ready_cnt - r0 !== 2 || ferr_cnt - f0 !== 0) begin
         n_err++;
         $display("[TB] FAIL b2b_pulses: got rdy=%0d ferr=%0d expected 2 0", ready_cnt - r0, ferr_cnt - f0);
      end
      n_vec++;
      if (rx_q.size() != 2 || rx_q[0] !== 8'hA3 || rx_q[1] !== 8'h00 || bus.data !== exp_data) begin
         n_err++;
         $display("[TB] FAIL b2b_order: got n=%0d first=%h last=%h expected 2 a3 00",
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, bus.data);
      end
   endtask

   task automatic test_glitch();
      int  r0, f0, p0;
      logic back;
      r0 = ready_cnt;
      f0 = ferr_cnt;
      p0 = perr_cnt;
      idle(BIT_CLKS);
      wd_low_seen = 1'b0;
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      back = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.waiting_data === 1'b1) begin
            back = 1'b1;
            break;
         end
      end
      n_vec++;
      if (back !== 1'b1 || wd_low_seen !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL glitch_waiting: got returned=%b left_idle=%b expected 1 1", back, wd_low_seen);
      end
      idle(2 * BIT_CLKS);
      n_vec++;
      if (ready_cnt != r0 || ferr_cnt != f0 || perr_cnt != p0 || bus.data !== exp_data) begin
         n_err++;
         $display("[TB] FAIL glitch_no_pulse: got rdy=%0d ferr=%0d perr=%0d data=%h expected 0 0 0 %h",
                  ready_cnt - r0, ferr_cnt - f0, perr_cnt - p0, bus.data, exp_data);
      end
   endtask

   task automatic test_frame_error();
      int   r0, f0;
      logic back;
      send_frame(8'h11, 1'b1, 1'b0);
      idle(4);
      exp_data = 8'h11;
      r0 = ready_cnt;
      f0 = ferr_cnt;
      send_frame(8'hFF, 1'b0, 1'b0);
      rxd = 1'b0;
      repeat (40) @(negedge clk);
      n_vec++;
      if (ferr_cnt - f0 !== 1 || ready_cnt != r0 || bus.data !== exp_data) begin
         n_err++;
         $display("[TB] FAIL ferr_pulse: got ferr=%0d rdy=%0d data=%h expected 1 0 %h",
                  ferr_cnt - f0, ready_cnt - r0, bus.data, exp_data);
      end
      n_vec++;
      if (bus.waiting_data !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL ferr_break_wait: got %b expected 0", bus.waiting_data);
      end
      rxd = 1'b1;
      back = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.waiting_data === 1'b1) begin
            back = 1'b1;
            break;
         end
      end
      n_vec++;
      if (back !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL ferr_release: got waiting=%b expected 1 within 8 clocks", bus.waiting_data);
      end
      idle(BIT_CLKS);
   endtask

   task automatic test_enable();
      int r0;
      r0 = ready_cnt;
      wd_low_seen = 1'b0;
      bus.enable_recv = 1'b0;
      send_frame(8'h12, 1'b1, 1'b0);
      idle(4);
      bus.enable_recv = 1'b1;
      idle(BIT_CLKS);
      n_vec++;
      if (ready_cnt != r0 || bus.data !== exp_data || wd_low_seen !== 1'b0) begin
         n_err++;
         $display("[TB] FAIL enable_gate: got rdy=%0d data=%h left_idle=%b expected 0 %h 0",
                  ready_cnt - r0, bus.data, wd_low_seen, exp_data);
      end
   endtask

   task automatic test_reset_midframe();
      int         r0;
      logic [7:0] b;
      b = 8'h7E;
      r0 = ready_cnt;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b[i]);
      rxd = b[4];
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (bus.data !== 8'h00 || bus.data_ready !== 1'b0 || bus.frame_error !== 1'b0 ||
          bus.parity_error !== 1'b0 || bus.waiting_data !== 1'b1) begin
         n_err++;
         $display("[TB] FAIL midframe_reset: got data=%h rdy=%b ferr=%b perr=%b wait=%b expected 00 0 0 0 1",
                  bus.data, bus.data_ready, bus.frame_error, bus.parity_error, bus.waiting_data);
      end
      rst = 1'b1;
      exp_data = 8'h00;
      rxd = 1'b1;
      drive_bit(1'b1);
      rx_q.delete();
      send_frame(8'h3C, 1'b1, 1'b0);
      idle(4);
      exp_data = 8'h3C;
      n_vec++;
      if (ready_cnt - r0 !== 1 || bus.data !== exp_data || rx_q.size() != 1) begin
         n_err++;
         $display("[TB] FAIL midframe_recover: got rdy=%0d data=%h expected 1 %h",
                  ready_cnt - r0, bus.data, exp_data);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int r0, p0;
      r0 = ready_cnt;
      p0 = perr_cnt;
      send_frame(8'h03, 1'b1, 1'b0);
      idle(4);
      exp_data = 8'h03;
      n_vec++;
      if (ready_cnt - r0 !== 1 || perr_cnt != p0 || bus.data !== exp_data) begin
         n_err++;
         $display("[TB] FAIL parity_good: got rdy=%0d perr=%0d data=%h expected 1 0 %h",
                  ready_cnt - r0, perr_cnt - p0, bus.data, exp_data);
      end
      r0 = ready_cnt;
      send_frame(8'h03, 1'b1, 1'b1);
      idle(4);
      n_vec++;
      if (ready_cnt != r0 || perr_cnt - p0 !== 1 || bus.data !== exp_data) begin
         n_err++;
         $display("[TB] FAIL parity_bad: got rdy=%0d perr=%0d data=%h expected 0 1 %h",
                  ready_cnt - r0, perr_cnt - p0, bus.data, exp_data);
      end
   endtask
`endif

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [7:0] b;
      int         gap;
      rx_q.delete();
      for (int k = 0; k < 12; k++) begin
         b   = 8'($urandom_range(0, 255));
         gap = int'($urandom_range(0, 20));
         idle(gap);
         send_frame(b, 1'b1, 1'b0);
         exp_q.push_back(b);
      end
      idle(4);
      exp_data = exp_q[exp_q.size() - 1];
      n_vec++;
      if (rx_q.size() != exp_q.size()) begin
         n_err++;
         $display("[TB] FAIL random_count: got %0d bytes expected %0d", rx_q.size(), exp_q.size());
      end
      for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
         n_vec++;
         if (rx_q[k] !== exp_q[k]) begin
            n_err++;
            $display("[TB] FAIL random_byte[%0d]: got %h expected %h", k, rx_q[k], exp_q[k]);
         end
      end
      n_vec++;
      if (bus.data !== exp_data) begin
         n_err++;
         $display("[TB] FAIL random_hold: got %h expected %h", bus.data, exp_data);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      ready_cnt = 0;
      ferr_cnt = 0;
      perr_cnt = 0;
      excl_viol = 0;
      wd_low_seen = 1'b0;
      wd_at_ready = 1'b0;
      rst = 1'b0;
      rxd = 1'b1;
      bus.enable_recv = 1'b1;
      @(negedge clk);

      test_reset();
      test_basic();
      test_back_to_back();
      test_glitch();
      test_frame_error();
      test_enable();
      test_reset_midframe();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_random();

      n_vec++;
      if (excl_viol != 0 || (perr_cnt != 0 && !`ifdef UART_RX_PARITY_EN 1'b1 `else 1'b0 `endif)) begin
         n_err++;
         $display("[TB] FAIL exclusive_pulses: got overlaps=%0d perr=%0d expected 0", excl_viol, perr_cnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
